// File: rtl/sar_pkg.sv
// ---------------------------------------------------------------------------
// sar_pkg
// Shared types and helpers for the successive-approximation search controller.
//   sar_state_t     : controller state encoding
//   SAR_WIDTH_DEF   : default trial/result width
//   verdict_onehot  : true when exactly one of gt/eq/lt is asserted
// ---------------------------------------------------------------------------
package sar_pkg;

    localparam int SAR_WIDTH_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESENT = 2'd1,
        ST_UPDATE  = 2'd2,
        ST_DONE    = 2'd3
    } sar_state_t;

    function automatic logic verdict_onehot(input logic gt, input logic eq, input logic lt);
        return (2'(gt) + 2'(eq) + 2'(lt)) == 2'd1;
    endfunction

endpackage

// File: rtl/sar_search_ctrl.sv
// ---------------------------------------------------------------------------
// sar_search_ctrl
// Binary-search (successive-approximation) controller driving one side of a
// magnitude comparator. Presents trial values MSB first, consumes gt/eq/lt
// verdicts and converges on the hidden target in WIDTH verdicts.
//
// Optional feature: define SAR_EARLY_EXIT_EN to finish as soon as an eq
// verdict is accepted (result = current trial). Without it, eq behaves as lt.
//
// Ports
//   i_clk           clock, all logic on rising edge
//   i_rst           synchronous active-high reset
//   i_start         begin a search (only honoured in IDLE)
//   o_trial         trial value presented to the comparator
//   o_trial_valid   trial stable and awaiting a verdict
//   i_fb_valid      verdict present this cycle
//   i_fb_gt/eq/lt   trial >, ==, < target
//   o_busy          search in progress
//   o_done          one-cycle pulse, o_result valid
//   o_result        converged value, held until next accepted start
//   o_err           sticky non-one-hot verdict flag, cleared by start
//
// state      | meaning
// -----------+--------------------------------------------------------------
// ST_IDLE    | waiting for start, outputs hold last trial/result
// ST_PRESENT | trial_valid high, waiting for a verdict on bit r_step
// ST_UPDATE  | one dead cycle: set next lower bit, trial_valid low
// ST_DONE    | done pulse, result valid
// ---------------------------------------------------------------------------
module sar_search_ctrl
    import sar_pkg::*;
#(
    parameter int WIDTH = SAR_WIDTH_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    output logic [WIDTH-1:0] o_trial,
    output logic             o_trial_valid,
    input  logic             i_fb_valid,
    input  logic             i_fb_gt,
    input  logic             i_fb_eq,
    input  logic             i_fb_lt,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result,
    output logic             o_err
);

    localparam int                STEP_W     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [STEP_W-1:0] STEP_MAX   = STEP_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0]  TRIAL_INIT = WIDTH'(1) << (WIDTH - 1);

    sar_state_t        r_state;
    logic [WIDTH-1:0]  r_trial;
    logic [WIDTH-1:0]  r_result;
    logic [STEP_W-1:0] r_step;
    logic              r_trial_valid;
    logic              r_busy;
    logic              r_done;
    logic              r_err;

    logic [WIDTH-1:0]  w_step_bit;
    logic [WIDTH-1:0]  w_trial_kept;
    logic              w_verdict_ok;

    assign w_step_bit   = WIDTH'(1) << r_step;
    // gt means the trial overshoots: the bit under test must be dropped
    assign w_trial_kept = i_fb_gt ? (r_trial & ~w_step_bit) : r_trial;
    assign w_verdict_ok = verdict_onehot(i_fb_gt, i_fb_eq, i_fb_lt);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= ST_IDLE;
            r_trial       <= '0;
            r_result      <= '0;
            r_step        <= STEP_MAX;
            r_trial_valid <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_trial       <= TRIAL_INIT;
                        r_step        <= STEP_MAX;
                        r_err         <= 1'b0;
                        r_trial_valid <= 1'b1;
                        r_busy        <= 1'b1;
                        r_state       <= ST_PRESENT;
                    end
                end

                ST_PRESENT: begin
                    if (i_fb_valid) begin
                        if (!w_verdict_ok) begin
                            // malformed verdict: abandon the search, keep old result
                            r_err         <= 1'b1;
                            r_trial_valid <= 1'b0;
                            r_busy        <= 1'b0;
                            r_state       <= ST_IDLE;
`ifdef SAR_EARLY_EXIT_EN
                        end else if (i_fb_eq) begin
                            // lower bits of the trial are already zero, so trial == target
                            r_result      <= r_trial;
                            r_trial_valid <= 1'b0;
                            r_done        <= 1'b1;
                            r_state       <= ST_DONE;
`endif
                        end else begin
                            r_trial       <= w_trial_kept;
                            r_trial_valid <= 1'b0;
                            if (r_step == '0) begin
                                r_result <= w_trial_kept;
                                r_done   <= 1'b1;
                                r_state  <= ST_DONE;
                            end else begin
                                r_state  <= ST_UPDATE;
                            end
                        end
                    end
                end

                ST_UPDATE: begin
                    r_trial       <= r_trial | (w_step_bit >> 1);
                    r_step        <= r_step - STEP_W'(1);
                    r_trial_valid <= 1'b1;
                    r_state       <= ST_PRESENT;
                end

                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_trial_valid <= 1'b0;
                    r_busy        <= 1'b0;
                    r_state       <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_trial       = r_trial;
    assign o_trial_valid = r_trial_valid;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_result      = r_result;
    assign o_err         = r_err;

endmodule

// File: tb/tb_sar_search_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sar_search_ctrl
// Closes the loop with a behavioural comparator on a hidden target.
// The expected trial sequence is derived arithmetically from the target:
// trial k keeps the target's bits above the bit under test and sets that bit.
// ---------------------------------------------------------------------------
module tb_sar_search_ctrl;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] trial;
    logic         trial_valid;
    logic         fb_valid;
    logic         fb_gt;
    logic         fb_eq;
    logic         fb_lt;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         err;

    sar_search_ctrl #(.WIDTH(W)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_start       (start),
        .o_trial       (trial),
        .o_trial_valid (trial_valid),
        .i_fb_valid    (fb_valid),
        .i_fb_gt       (fb_gt),
        .i_fb_eq       (fb_eq),
        .i_fb_lt       (fb_lt),
        .o_busy        (busy),
        .o_done        (done),
        .o_result      (result),
        .o_err         (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;

    // scenario controls, written by the driver at negedges
    int tgt      = 0;
    int stall    = 0;
    bit noise    = 1'b0;
    bit err_mode = 1'b0;
    bit active   = 1'b0;
    bit done_seen = 1'b0;

    // model state, written by the monitor at posedge+1
    int n_acc = 0;
    int cyc   = 0;
    int obs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int model_trial(input int t, input int idx);
        int s;
        s = W - 1 - idx;
        return ((t >> (s + 1)) << (s + 1)) | (1 << s);
    endfunction

    function automatic int n_exp(input int t);
`ifdef SAR_EARLY_EXIT_EN
        if (t == 0) return W;
        for (int b = 0; b < W; b++)
            if (((t >> b) & 1) == 1) return W - b;
        return W;
`else
        return W;
`endif
    endfunction

    // responder: behavioural comparator with optional stall, noise and bad verdicts
    int stall_cnt = 0;
    always @(negedge clk) begin
        if (!rst) begin
            if (trial_valid) begin
                if (stall_cnt >= stall) begin
                    fb_valid = 1'b1;
                    fb_gt    = (int'(trial) > tgt);
                    fb_eq    = (int'(trial) == tgt);
                    fb_lt    = (int'(trial) < tgt);
                    if (err_mode && n_acc == 1) begin
                        fb_gt = 1'b1;
                        fb_eq = 1'b0;
                        fb_lt = 1'b1;
                    end
                end else begin
                    fb_valid = 1'b0;
                    stall_cnt++;
                end
            end else begin
                stall_cnt = 0;
                if (noise && busy) begin
                    fb_valid = 1'b1; fb_gt = 1'b1; fb_eq = 1'b1; fb_lt = 1'b1;
                end else begin
                    fb_valid = 1'b0; fb_gt = 1'b0; fb_eq = 1'b0; fb_lt = 1'b0;
                end
            end
        end
    end

    // compare process
    logic         prev_tv    = 1'b0;
    logic         prev_busy  = 1'b0;
    logic [W-1:0] prev_trial = '0;
    always @(posedge clk) begin
        bit accepted;
        #1;
        if (rst) begin
            prev_tv = 1'b0; prev_busy = 1'b0; prev_trial = '0;
        end else begin
            accepted = prev_tv && fb_valid;
            if (start && !prev_busy) begin
                cyc   = 1;
                n_acc = 0;
            end else begin
                cyc++;
                if (active && accepted) n_acc++;
            end
            if (active && trial_valid) begin
                if (prev_tv && !accepted) begin
                    check("trial_stable", trial, prev_trial);
                end else begin
                    check("trial_seq", trial, model_trial(tgt, n_acc));
                    if (n_acc < 8) obs[n_acc] = int'(trial);
                end
            end
            if (done) begin
                done_seen = 1'b1;
                if (active) begin
                    check("result", result, tgt);
                    check("err_at_done", err, 0);
                    check("n_verdicts", n_acc, n_exp(tgt));
                    check("done_cycle", cyc, n_exp(tgt) * (2 + stall));
                end
            end
            prev_tv = trial_valid; prev_busy = busy; prev_trial = trial;
        end
    end

    task automatic check_obs(input string name, input int a, input int b, input int c, input int d);
        int lit [4];
        lit = '{a, b, c, d};
        for (int i = 0; i < n_exp(tgt); i++) check(name, obs[i], lit[i]);
    endtask

    task automatic run(input int t, input int s, input bit mid, input bit nz, input bit em);
        int prev_result;
        tgt = t; stall = s; noise = nz; err_mode = em;
        done_seen = 1'b0; active = 1'b1;
        for (int i = 0; i < 8; i++) obs[i] = -1;
        prev_result = int'(result);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (done_seen) break;
            if (em && n_acc >= 2 && !busy) break;
            start = (mid && i == 4);
            @(negedge clk);
        end
        start = 1'b0;
        if (em) begin
            check("err_set", err, 1);
            check("err_busy", busy, 0);
            check("err_no_done", done_seen, 0);
            check("err_result_kept", result, prev_result);
        end else begin
            check("done_timeout", done_seen, 1);
            @(posedge clk); #2;
            check("busy_after_done", busy, 0);
            check("done_one_cycle", done, 0);
            check("trial_hold", trial, tgt);
        end
        noise = 1'b0; err_mode = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0;
        fb_valid = 1'b0; fb_gt = 1'b0; fb_eq = 1'b0; fb_lt = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("rst_trial", trial, 0);
        check("rst_tv", trial_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_err", err, 0);
        @(negedge clk) rst = 1'b0;

        run(11, 0, 1'b0, 1'b0, 1'b0);
        check_obs("seq_t11", 8, 12, 10, 11);
        run(8, 0, 1'b0, 1'b0, 1'b0);
        check_obs("seq_t8", 8, 12, 10, 9);
        run(0, 0, 1'b0, 1'b0, 1'b0);
        check_obs("seq_t0", 8, 4, 2, 1);
        run(15, 0, 1'b0, 1'b0, 1'b0);
        check_obs("seq_t15", 8, 12, 14, 15);
        run(10, 3, 1'b1, 1'b1, 1'b0);
        check_obs("seq_t10_stall", 8, 12, 10, 11);
        run(13, 0, 1'b0, 1'b0, 1'b1);
        run(6, 0, 1'b0, 1'b0, 1'b0);
        check_obs("seq_t6", 8, 4, 6, 7);

        // reset while presenting the step-1 trial
        tgt = 5; stall = 0; done_seen = 1'b0; active = 1'b1;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (trial_valid && n_acc == 2) break;
            @(negedge clk);
        end
        check("rst_mid_reached", n_acc, 2);
        active = 1'b0;
        rst = 1'b1;
        @(posedge clk); #2;
        check("rstm_trial", trial, 0);
        check("rstm_tv", trial_valid, 0);
        check("rstm_busy", busy, 0);
        check("rstm_done", done, 0);
        check("rstm_result", result, 0);
        check("rstm_err", err, 0);
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        run(9, 0, 1'b0, 1'b0, 1'b0);
        check_obs("seq_t9", 8, 12, 10, 9);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
